// File: rtl/alu_pkg.sv
// Shared ALU operation codes and execution-unit state encoding.
package alu_pkg;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1001;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic {IDLE, MUL_RUN} state_t;
endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles total.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             run,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc, mcand, mplier, acc_next;

    assign acc_next = acc + (mplier[0] ? mcand : '0);
    // The final partial product is folded in combinationally so the result lands on the done cycle.
    assign product  = acc_next;
    assign done     = run && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (start) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else if (run) begin
            cnt    <= cnt + CW'(1);
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end
endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage execution unit: two-stage single-cycle datapath plus iterative MUL.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_signal,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [4:0]       shamt,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal_op,
    output logic             busy
);
    state_t           state;
    logic             accept, is_mul, mul_done;
    logic [WIDTH-1:0] mul_product, sum, diff, alu_res, s1_result;
    logic             alu_ovf, alu_ill, s1_valid, s1_ovf, s1_ill;

    assign in_ready = (state == IDLE) && !flush;
    assign busy     = (state == MUL_RUN);
    assign accept   = in_valid && in_ready;
    assign is_mul   = (alu_signal == ALU_MUL);
    assign sum      = op_a + op_b;
    assign diff     = op_a - op_b;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (alu_signal)
            ALU_AND: alu_res = op_a & op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_XOR: alu_res = op_a ^ op_b;
            ALU_NOR: alu_res = ~(op_a | op_b);
            ALU_ADD: begin
                alu_res = sum;
                alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res = diff;
                alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLL: alu_res = op_b << shamt;
            ALU_SRL: alu_res = op_b >> shamt;
            // Vacated high bits take the sign of op_a, the shifted data comes from op_b.
            ALU_SRA: alu_res = (op_b >> shamt) |
                               ({WIDTH{op_a[WIDTH-1]}} & ~({WIDTH{1'b1}} >> shamt));
            ALU_MUL: alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mul),
        .run     (busy && !flush),
        .flush   (flush),
        .a       (op_a),
        .b       (op_b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            s1_valid   <= 1'b0;
            s1_result  <= '0;
            s1_ovf     <= 1'b0;
            s1_ill     <= 1'b0;
            out_valid  <= 1'b0;
            result     <= '0;
            zero       <= 1'b0;
            overflow   <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            s1_valid  <= 1'b0;
            if (flush) begin
                // Squashes both an in-flight MUL and a staged single-cycle op.
                state <= IDLE;
            end else begin
                if (s1_valid) begin
                    out_valid  <= 1'b1;
                    result     <= s1_result;
                    zero       <= (s1_result == '0);
                    overflow   <= s1_ovf;
                    illegal_op <= s1_ill;
                end
                if (mul_done) begin
                    state      <= IDLE;
                    out_valid  <= 1'b1;
                    result     <= mul_product;
                    zero       <= (mul_product == '0);
                    overflow   <= 1'b0;
                    illegal_op <= 1'b0;
                end
                if (accept) begin
                    if (is_mul) begin
                        state <= MUL_RUN;
                    end else begin
                        s1_valid  <= 1'b1;
                        s1_result <= alu_res;
                        s1_ovf    <= alu_ovf;
                        s1_ill    <= alu_ill;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench: vector table plus scoreboard with per-result due-cycle checks.
module tb_alu_exec_unit;
    localparam int W = 32;

    logic         clk, rst_n, flush, in_valid, in_ready;
    logic [3:0]   alu_signal;
    logic [W-1:0] op_a, op_b, result;
    logic [4:0]   shamt;
    logic         out_valid, zero, overflow, illegal_op, busy;

    typedef struct {
        logic [3:0]   sig;
        logic [W-1:0] a, b;
        logic [4:0]   sh;
        logic [W-1:0] res;
        logic         ovf, ill;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         ovf, ill;
        int           due;
    } exp_t;

    exp_t sb[$];
    vec_t vt[16];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_signal(alu_signal), .op_a(op_a), .op_b(op_b), .shamt(shamt),
        .out_valid(out_valid), .result(result), .zero(zero), .overflow(overflow),
        .illegal_op(illegal_op), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one op and hold it until accepted; record the expected result and its due cycle.
    task automatic issue(input vec_t v, input int lat);
        int tries = 0;
        @(negedge clk);
        in_valid = 1'b1; alu_signal = v.sig; op_a = v.a; op_b = v.b; shamt = v.sh;
        #1;
        while (!in_ready && tries < 100) begin
            @(negedge clk);
            #1;
            tries++;
        end
        if (!in_ready) begin
            chk("issue_timeout", 32'd0, 32'd1);
        end else begin
            exp_t e;
            e.res = v.res; e.ovf = v.ovf; e.ill = v.ill; e.due = cyc + 1 + lat;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("latency_cycle", cyc, e.due);
                    chk("result", result, e.res);
                    chk("zero", {31'd0, zero}, {31'd0, e.res == '0});
                    chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
                    chk("illegal_op", {31'd0, illegal_op}, {31'd0, e.ill});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t m;
        vt[0]  = '{4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 1'b1, 1'b0};
        vt[1]  = '{4'b0110, 32'h0000_0005, 32'h0000_0005, 5'd0,  32'h0000_0000, 1'b0, 1'b0};
        vt[2]  = '{4'b0000, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 5'd0,  32'h00F0_A5A5, 1'b0, 1'b0};
        vt[3]  = '{4'b0001, 32'h1234_0000, 32'h0000_5678, 5'd0,  32'h1234_5678, 1'b0, 1'b0};
        vt[4]  = '{4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0001, 1'b0, 1'b0};
        vt[5]  = '{4'b1001, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0, 1'b0};
        vt[6]  = '{4'b0011, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0,  32'hF0F0_0F0F, 1'b0, 1'b0};
        vt[7]  = '{4'b0100, 32'h1234_5678, 32'h0000_0003, 5'd4,  32'h0000_0030, 1'b0, 1'b0};
        vt[8]  = '{4'b0101, 32'h0000_0000, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 1'b0};
        vt[9]  = '{4'b1100, 32'h0000_0000, 32'h0000_0000, 5'd0,  32'hFFFF_FFFF, 1'b0, 1'b0};
        vt[10] = '{4'b0110, 32'h8000_0000, 32'h0000_0001, 5'd0,  32'h7FFF_FFFF, 1'b1, 1'b0};
        vt[11] = '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b0, 1'b0};
        vt[12] = '{4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000, 1'b0, 1'b0};
        vt[13] = '{4'b1111, 32'h0000_0005, 32'h0000_0005, 5'd0,  32'h0000_0000, 1'b0, 1'b1};
        vt[14] = '{4'b1010, 32'hFFFF_FFFF, 32'h0000_0003, 5'd0,  32'h0000_0000, 1'b0, 1'b1};
        vt[15] = '{4'b1001, 32'h4000_0000, 32'h4000_0000, 5'd2,  32'h1000_0000, 1'b0, 1'b0};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        alu_signal = 4'd0; op_a = '0; op_b = '0; shamt = '0;
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {28'd0, zero, overflow, illegal_op, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Back-to-back single-cycle ops
        for (int i = 0; i < 16; i++) issue(vt[i], 1);
        idle(3);
        chk("hold_out_valid", {31'd0, out_valid}, 32'd0);
        chk("hold_result", result, 32'h1000_0000);

        // MUL with a held in_valid behind it
        m = '{4'b1000, 32'h0000_FFFF, 32'h0001_0001, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0};
        issue(m, W);
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            in_valid = 1'b1; alu_signal = 4'b0010; op_a = 32'd1; op_b = 32'd2;
            #1;
            chk("mul_busy", {31'd0, busy}, 32'd1);
            chk("mul_in_ready", {31'd0, in_ready}, 32'd0);
        end
        m = '{4'b0010, 32'd1, 32'd2, 5'd0, 32'd3, 1'b0, 1'b0};
        issue(m, 1);
        m = '{4'b1000, 32'h8000_0001, 32'h0000_0003, 5'd0, 32'h8000_0003, 1'b0, 1'b0};
        issue(m, W);
        idle(W + 3);

        // Flush at MUL cycle 10
        m = '{4'b1000, 32'h0000_1234, 32'h0000_5678, 5'd0, 32'h0626_0060, 1'b0, 1'b0};
        issue(m, W);
        idle(10);
        @(negedge clk);
        flush = 1'b1;
        void'(sb.pop_back());
        #1;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        chk("flush_busy_before", {31'd0, busy}, 32'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_idle_busy", {31'd0, busy}, 32'd0);
        chk("flush_idle_ready", {31'd0, in_ready}, 32'd1);
        idle(W + 3);

        // Flush squashes a single-cycle op accepted on the previous edge
        m = '{4'b0010, 32'd7, 32'd8, 5'd0, 32'd15, 1'b0, 1'b0};
        issue(m, 1);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        flush = 1'b0;
        chk("flush_single_no_valid", {31'd0, out_valid}, 32'd0);
        // Flush wins over in_valid
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; alu_signal = 4'b0001;
        #1;
        chk("flush_wins_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        idle(3);
        chk("flush_wins_no_valid", {31'd0, out_valid}, 32'd0);

        // Async reset mid-MUL
        m = '{4'b1000, 32'h0000_0003, 32'h0000_0004, 5'd0, 32'h0000_000C, 1'b0, 1'b0};
        issue(m, W);
        idle(5);
        #2;
        rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        idle(W + 3);

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
